// File: rtl/icap_reg_access.sv
// Single-register ICAPE2 (X32) initiator: sync, Type-1 packet, data or read turnaround, desync.
// ICAP outputs are registered one cycle behind the state that selects them.
module icap_reg_access #(
  parameter bit          BIT_SWAP = 1'b1,
  parameter int unsigned READ_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  input  logic [31:0] icap_o
);

  localparam logic [31:0] NOOP      = 32'h20000000;
  localparam logic [31:0] SYNC      = 32'hAA995566;
  localparam logic [31:0] DUMMY     = 32'hFFFFFFFF;
  localparam logic [31:0] CMD_HDR   = 32'h30008001;
  localparam logic [31:0] DESYNC    = 32'h0000000D;
  localparam logic [31:0] RDHDR_B   = 32'h28000001;
  localparam logic [31:0] WRHDR_B   = 32'h30000001;
  localparam logic [3:0]  WAIT_LAST = 4'(READ_LAT - 1);

  typedef enum logic [2:0] {IDLE, WBURST, RBURST, TURN1, RWAIT, TURN2, DBURST, FIN} state_t;

  state_t      state;
  logic [3:0]  idx;
  logic [3:0]  wcnt;
  logic        wr_q;
  logic [4:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] hold;

  // Per-byte bit reversal; it is its own inverse, so it serves both directions.
  function automatic logic [31:0] phys(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[i] = x[(i / 8) * 8 + 7 - (i % 8)];
    return BIT_SWAP ? y : x;
  endfunction

  function automatic logic [31:0] wr_word(input logic [3:0] k, input logic [4:0] a,
                                          input logic [31:0] d);
    case (k)
      4'd0:    return DUMMY;
      4'd1:    return SYNC;
      4'd3:    return WRHDR_B | (32'(a) << 13);
      4'd4:    return d;
      4'd5:    return CMD_HDR;
      4'd6:    return DESYNC;
      default: return NOOP;
    endcase
  endfunction

  function automatic logic [31:0] rd_word(input logic [3:0] k, input logic [4:0] a);
    case (k)
      4'd0:    return DUMMY;
      4'd1:    return SYNC;
      4'd3:    return RDHDR_B | (32'(a) << 13);
      default: return NOOP;
    endcase
  endfunction

  function automatic logic [31:0] ds_word(input logic [3:0] k);
    case (k)
      4'd0:    return CMD_HDR;
      4'd1:    return DESYNC;
      default: return NOOP;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 4'd0;
      wcnt       <= 4'd0;
      wr_q       <= 1'b0;
      addr_q     <= 5'd0;
      wdata_q    <= 32'd0;
      hold       <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= 32'd0;
      icap_csib  <= 1'b1;
      icap_rdwrb <= 1'b0;
      icap_i     <= DUMMY;
    end else begin
      done      <= 1'b0;
      icap_csib <= 1'b1;
      icap_i    <= DUMMY;
      case (state)
        IDLE: begin
          icap_rdwrb <= 1'b0;
          if (req) begin
            wr_q    <= wr;
            addr_q  <= addr;
            wdata_q <= wdata;
            busy    <= 1'b1;
            idx     <= 4'd0;
            wcnt    <= 4'd0;
            state   <= wr ? WBURST : RBURST;
          end
        end
        WBURST: begin
          icap_csib  <= 1'b0;
          icap_rdwrb <= 1'b0;
          icap_i     <= phys(wr_word(idx, addr_q, wdata_q));
          if (idx == 4'd8) begin
            idx   <= 4'd0;
            state <= FIN;
          end else idx <= idx + 4'd1;
        end
        RBURST: begin
          icap_csib  <= 1'b0;
          icap_rdwrb <= 1'b0;
          icap_i     <= phys(rd_word(idx, addr_q));
          if (idx == 4'd5) begin
            idx   <= 4'd0;
            state <= TURN1;
          end else idx <= idx + 4'd1;
        end
        TURN1: begin
          // Deselected cycle so RDWRB rises while CSIB is high.
          icap_rdwrb <= 1'b1;
          wcnt       <= 4'd0;
          state      <= RWAIT;
        end
        RWAIT: begin
          icap_csib  <= 1'b0;
          icap_rdwrb <= 1'b1;
          if (wcnt == WAIT_LAST) begin
            wcnt  <= 4'd0;
            state <= TURN2;
          end else wcnt <= wcnt + 4'd1;
        end
        TURN2: begin
          // icap_o here reflects the last selected read cycle.
          hold       <= phys(icap_o);
          icap_rdwrb <= 1'b0;
          idx        <= 4'd0;
          state      <= DBURST;
        end
        DBURST: begin
          icap_csib  <= 1'b0;
          icap_rdwrb <= 1'b0;
          icap_i     <= phys(ds_word(idx));
          if (idx == 4'd3) begin
            idx   <= 4'd0;
            state <= FIN;
          end else idx <= idx + 4'd1;
        end
        FIN: begin
          icap_rdwrb <= 1'b0;
          done       <= 1'b1;
          busy       <= 1'b0;
          if (!wr_q) rdata <= hold;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
